// File: rtl/alu_regfile_pkg.sv
// Shared definitions for the register-mapped ALU.
//   - register map addresses (ADDR_OPA .. ADDR_RES_HI, first general-purpose slot)
//   - STATUS bit positions
//   - opcode and FSM state enums
package alu_regfile_pkg;

    localparam int unsigned ADDR_OPA    = 0;
    localparam int unsigned ADDR_OPB    = 1;
    localparam int unsigned ADDR_OP     = 2;
    localparam int unsigned ADDR_CTRL   = 3;
    localparam int unsigned ADDR_STATUS = 4;
    localparam int unsigned ADDR_RES_LO = 5;
    localparam int unsigned ADDR_RES_HI = 6;
    localparam int unsigned ADDR_GP     = 7;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_DIV0    = 2;
    localparam int unsigned STAT_ILLEGAL = 3;

    typedef enum logic [2:0] {
        OP_CLR = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_XOR = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_regfile_if.sv
// Register-access bus of alu_regfile.
//   enable   access strobe, one access per cycle
//   rd_wr    1 = read, 0 = write
//   addr     register address
//   wr_data  write data
//   rd_data  registered read data
//   res_out  registered 2*DATA_WIDTH result
//   busy     mirrors STATUS.BUSY
//   done     mirrors STATUS.DONE
interface alu_regfile_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                    enable;
    logic                    rd_wr;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [2*DATA_WIDTH-1:0] res_out;
    logic                    busy;
    logic                    done;

    modport master (
        output enable, rd_wr, addr, wr_data,
        input  rd_data, res_out, busy, done
    );

    modport slave (
        input  enable, rd_wr, addr, wr_data,
        output rd_data, res_out, busy, done
    );
endinterface

// File: rtl/alu_seq_divider.sv
// W-cycle unsigned restoring divider, compiled only when ALU_DIV_EN is defined.
//   clk, rst            clock, asynchronous active-low reset
//   start               load operands and begin (one-cycle pulse)
//   dividend, divisor   operands sampled with start (divisor must be non-zero)
//   quotient, remainder result, stable once valid has pulsed
//   valid               one-cycle pulse after the W-th iteration
`ifdef ALU_DIV_EN
module alu_seq_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         valid
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  quo_q, rem_q, dvs_q;
    logic [CW-1:0] cnt_q;
    logic          valid_q;
    logic [W:0]    shifted;
    logic          fits;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign shifted = {rem_q, quo_q[W-1]};
    assign fits    = (shifted >= {1'b0, dvs_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (start) begin
            quo_q   <= dividend;
            rem_q   <= '0;
            dvs_q   <= divisor;
            cnt_q   <= CW'(W);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            // After a successful subtract the remainder is below the divisor,
            // so it always fits back into W bits.
            rem_q   <= fits ? W'(shifted - {1'b0, dvs_q}) : shifted[W-1:0];
            quo_q   <= {quo_q[W-2:0], fits};
            cnt_q   <= cnt_q - 1'b1;
            valid_q <= (cnt_q == CW'(1));
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = valid_q;
endmodule
`endif

// File: rtl/alu_regfile.sv
// Register-mapped ALU with a 2^ADDR_WIDTH word register file and status flags.
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   alu_regfile_if.slave: enable/rd_wr/addr/wr_data in,
//         rd_data/res_out/busy/done out
// Build option: define ALU_DIV_EN to include the multi-cycle divider for
// opcode 4; without it opcode 4 completes in one cycle and flags ILLEGAL.
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input logic          clk,
    input logic          rst,
    alu_regfile_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned RW    = 2 * DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] A_OPA    = ADDR_WIDTH'(ADDR_OPA);
    localparam logic [ADDR_WIDTH-1:0] A_OPB    = ADDR_WIDTH'(ADDR_OPB);
    localparam logic [ADDR_WIDTH-1:0] A_OP     = ADDR_WIDTH'(ADDR_OP);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(ADDR_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(ADDR_STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_RES_LO = ADDR_WIDTH'(ADDR_RES_LO);
    localparam logic [ADDR_WIDTH-1:0] A_RES_HI = ADDR_WIDTH'(ADDR_RES_HI);
    localparam logic [ADDR_WIDTH-1:0] A_GP     = ADDR_WIDTH'(ADDR_GP);

    state_e                state, state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    opcode_e               op_q, lat_op;
    logic [DATA_WIDTH-1:0] lat_a, lat_b, rd_q, rd_mux;
    logic [RW-1:0]         res_q, alu_res, res_next;
    logic                  busy_q, done_q, div0_q, illegal_q;
    logic                  wr_en, rd_en, start_req, start_ok, load_res, exec_done;
    logic                  div0_hit, illegal_hit;

    assign wr_en     = bus.enable && !bus.rd_wr;
    assign rd_en     = bus.enable &&  bus.rd_wr;
    assign start_req = wr_en && (bus.addr == A_CTRL) && bus.wr_data[0];

`ifdef ALU_DIV_EN
    logic                  div_start, div_valid;
    logic [DATA_WIDTH-1:0] div_quo, div_rem;

    alu_seq_divider #(.W(DATA_WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (mem[A_OPA]),
        .divisor   (mem[A_OPB]),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    assign res_next = (state == ST_DIV) ? {div_rem, div_quo} : alu_res;
`else
    assign res_next = alu_res;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // DONE behaves like IDLE for one cycle so a START right after completion
    // is accepted without a dead cycle.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        load_res   = 1'b0;
        exec_done  = 1'b0;
`ifdef ALU_DIV_EN
        div_start  = 1'b0;
`endif
        unique case (state)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (start_req) begin
                    start_ok   = 1'b1;
                    state_next = ST_EXEC;
`ifdef ALU_DIV_EN
                    if (op_q == OP_DIV && mem[A_OPB] != '0) begin
                        state_next = ST_DIV;
                        div_start  = 1'b1;
                    end
`endif
                end
            end
            ST_EXEC: begin
                load_res   = 1'b1;
                exec_done  = 1'b1;
                state_next = ST_DONE;
            end
            ST_DIV: begin
`ifdef ALU_DIV_EN
                if (div_valid) begin
                    load_res   = 1'b1;
                    state_next = ST_DONE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Single-cycle operations; in EXEC a divide always means divisor zero
    // (or no divider built).
    always_comb begin
        alu_res     = res_q;
        div0_hit    = 1'b0;
        illegal_hit = 1'b0;
        unique case (lat_op)
            OP_CLR: alu_res = '0;
            OP_ADD: alu_res = RW'(lat_a) + RW'(lat_b);
            OP_SUB: alu_res = RW'(lat_a) - RW'(lat_b);
            OP_MUL: alu_res = RW'(lat_a) * RW'(lat_b);
            OP_DIV: begin
`ifdef ALU_DIV_EN
                alu_res  = '1;
                div0_hit = 1'b1;
`else
                illegal_hit = 1'b1;
`endif
            end
            OP_AND: alu_res = RW'(lat_a & lat_b);
            OP_OR:  alu_res = RW'(lat_a | lat_b);
            OP_XOR: alu_res = RW'(lat_a ^ lat_b);
            default: alu_res = res_q;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            A_OP:     rd_mux = DATA_WIDTH'(op_q);
            A_CTRL:   rd_mux = '0;
            A_STATUS: begin
                rd_mux[STAT_BUSY]    = busy_q;
                rd_mux[STAT_DONE]    = done_q;
                rd_mux[STAT_DIV0]    = div0_q;
                rd_mux[STAT_ILLEGAL] = illegal_q;
            end
            A_RES_LO: rd_mux = res_q[DATA_WIDTH-1:0];
            A_RES_HI: rd_mux = res_q[RW-1:DATA_WIDTH];
            default:  rd_mux = mem[bus.addr];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '1;
            op_q      <= OP_XOR;
            lat_op    <= OP_XOR;
            lat_a     <= '1;
            lat_b     <= '1;
            res_q     <= '0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (wr_en) begin
                case (bus.addr)
                    A_OPA, A_OPB: mem[bus.addr] <= bus.wr_data;
                    A_OP:         op_q <= opcode_e'(bus.wr_data[2:0]);
                    default:      if (bus.addr >= A_GP) mem[bus.addr] <= bus.wr_data;
                endcase
            end

            // Completion outranks a concurrent W1C so DONE is never lost.
            if (start_ok) begin
                lat_a     <= mem[A_OPA];
                lat_b     <= mem[A_OPB];
                lat_op    <= op_q;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                div0_q    <= 1'b0;
                illegal_q <= 1'b0;
            end else if (load_res) begin
                res_q  <= res_next;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                if (exec_done) begin
                    div0_q    <= div0_hit;
                    illegal_q <= illegal_hit;
                end
            end else if (wr_en && bus.addr == A_STATUS && bus.wr_data[STAT_DONE]) begin
                done_q <= 1'b0;
            end

            if (rd_en) rd_q <= rd_mux;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.res_out = res_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
